// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared 16-bit Fibonacci LFSR constants, checker states and feedback function
package lfsr_pkg;

  localparam int LFSR_W = 16;
  // Taps at bits 15, 13, 12 and 10; the generator uses the same mask.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {SEARCH, LOCKED} chk_state_t;

  function automatic logic lfsr_fb(input logic [LFSR_W-1:0] hist);
    return ^(hist & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
// A clear coinciding with an increment loads 1 so the event is not lost.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = {{(W-1){1'b0}}, inc_i};
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/prbs_checker.sv
// rtl/prbs_checker.sv - self-synchronising PRBS16 checker with lock tracking and error counting
// SEARCH loads received bits into the history; LOCKED flywheels on its own prediction.
module prbs_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_COUNT  = 32,
  parameter int UNLOCK_ERRS = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
);

  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int BAD_W  = $clog2(UNLOCK_ERRS + 1);
  localparam int FILL_W = $clog2(LFSR_W + 1);

  chk_state_t        state_q, state_d;
  logic [LFSR_W-1:0] hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [BAD_W-1:0]  bad_q, bad_d;
  logic              err_pulse_q, err_pulse_d;
  logic              pred;
  logic              mismatch;
  logic              err_inc;

  assign pred     = lfsr_fb(hist_q);
  assign mismatch = (in_bit != pred);

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    run_d   = run_q;
    bad_d   = bad_q;
    err_inc = 1'b0;
    if (in_valid) begin
      case (state_q)
        SEARCH: begin
          hist_d = {hist_q[LFSR_W-2:0], in_bit};
          if (fill_q != FILL_W'(LFSR_W)) begin
            fill_d = fill_q + 1'b1;
            run_d  = '0;
          end else if ((hist_q == '0) || mismatch) begin
            // An all-zero history predicts zero forever, so it must never build a run.
            run_d = '0;
          end else begin
            run_d = run_q + 1'b1;
            if (run_q == RUN_W'(LOCK_COUNT - 1)) begin
              state_d = LOCKED;
            end
          end
        end
        LOCKED: begin
          hist_d = {hist_q[LFSR_W-2:0], pred};
          if (!mismatch) begin
            bad_d = '0;
          end else begin
            err_inc = 1'b1;
            bad_d   = bad_q + 1'b1;
            if (bad_q == BAD_W'(UNLOCK_ERRS - 1)) begin
              state_d = SEARCH;
              fill_d  = '0;
              run_d   = '0;
              bad_d   = '0;
            end
          end
        end
      endcase
    end
    err_pulse_d = err_inc;
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      state_q     <= SEARCH;
      hist_q      <= '0;
      fill_q      <= '0;
      run_q       <= '0;
      bad_q       <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      run_q       <= run_d;
      bad_q       <= bad_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_err_cnt (
    .clk    (clk),
    .nReset (nReset),
    .clr_i  (clear_cnt),
    .inc_i  (err_inc),
    .count_o(err_count)
  );

  assign locked    = (state_q == LOCKED);
  assign err_pulse = err_pulse_q;

endmodule

// File: tb/tb_prbs_checker.sv
// tb/tb_prbs_checker.sv - directed self-checking bench for prbs_checker with a queue-based reference model
module tb_prbs_checker;

  localparam int LOCK_COUNT  = 32;
  localparam int UNLOCK_ERRS = 4;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             nReset = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_bit = 1'b0;
  logic             clear_cnt = 1'b0;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] g;

  prbs_checker #(
    .LOCK_COUNT (LOCK_COUNT),
    .UNLOCK_ERRS(UNLOCK_ERRS),
    .CNT_W      (CNT_W)
  ) dut (
    .clk      (clk),
    .nReset   (nReset),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .clear_cnt(clear_cnt),
    .locked   (locked),
    .err_pulse(err_pulse),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: history is a queue of the last 16 bits, oldest first, so
  // the feedback taps 15/13/12/10 are the bits 16, 14, 13 and 11 beats back.
  bit mq[$];
  bit m_locked = 1'b0;
  bit m_pulse = 1'b0;
  int m_run = 0;
  int m_bad = 0;
  int m_cnt = 0;
  bit m_pred;
  bit m_zero;
  bit m_err;

  always @(posedge clk) begin
    if (!nReset) begin
      mq.delete();
      m_locked = 1'b0;
      m_pulse  = 1'b0;
      m_run    = 0;
      m_bad    = 0;
      m_cnt    = 0;
    end else begin
      m_pulse = 1'b0;
      m_err   = 1'b0;
      if (in_valid) begin
        m_pred = 1'b0;
        m_zero = 1'b1;
        if (mq.size() == 16) m_pred = mq[0] ^ mq[2] ^ mq[3] ^ mq[5];
        foreach (mq[i]) if (mq[i]) m_zero = 1'b0;
        if (!m_locked) begin
          if (mq.size() < 16)         m_run = 0;
          else if (m_zero)            m_run = 0;
          else if (in_bit == m_pred)  m_run = m_run + 1;
          else                        m_run = 0;
          mq.push_back(in_bit);
          if (mq.size() > 16) void'(mq.pop_front());
          if (m_run == LOCK_COUNT) m_locked = 1'b1;
        end else begin
          mq.push_back(m_pred);
          void'(mq.pop_front());
          if (in_bit == m_pred) begin
            m_bad = 0;
          end else begin
            m_err   = 1'b1;
            m_pulse = 1'b1;
            m_bad   = m_bad + 1;
            if (m_bad == UNLOCK_ERRS) begin
              m_locked = 1'b0;
              mq.delete();
              m_run = 0;
              m_bad = 0;
            end
          end
        end
      end
      if (clear_cnt)                     m_cnt = m_err ? 1 : 0;
      else if (m_err && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end
    #1;
    chk("model_locked", locked, m_locked);
    chk("model_err_pulse", err_pulse, m_pulse);
    chk("model_err_count", err_count, m_cnt);
  end

  task automatic next_bit(output bit b);
    b = g[15] ^ g[13] ^ g[12] ^ g[10];
    g = {g[14:0], b};
  endtask

  task automatic raw_beat(input bit b, input bit clr);
    @(negedge clk);
    in_valid  = 1'b1;
    in_bit    = b;
    clear_cnt = clr;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    clear_cnt = 1'b0;
  endtask

  task automatic beat(input bit flip, input bit clr);
    bit b;
    next_bit(b);
    raw_beat(b ^ flip, clr);
  endtask

  task automatic idle(input bit clr);
    @(negedge clk);
    in_valid  = 1'b0;
    clear_cnt = clr;
    @(posedge clk);
    #1;
    clear_cnt = 1'b0;
  endtask

  task automatic clean(input int n);
    repeat (n) beat(1'b0, 1'b0);
  endtask

  task automatic lock_check(input string tag);
    clean(LOCK_COUNT + 15);
    chk({tag, "_pre_lock"}, locked, 1'b0);
    clean(1);
    chk({tag, "_lock"}, locked, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    nReset   = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    nReset = 1'b1;
    chk("rst_locked", locked, 1'b0);
    chk("rst_err_pulse", err_pulse, 1'b0);
    chk("rst_err_count", err_count, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit b0, b1;
    repeat (2) @(posedge clk);
    #1;
    nReset = 1'b1;
    chk("rst_locked", locked, 1'b0);
    chk("rst_err_pulse", err_pulse, 1'b0);
    chk("rst_err_count", err_count, 0);

    // Seed ACE1 yields feedback 1 then 1.
    g = 16'hACE1;
    next_bit(b0);
    next_bit(b1);
    chk("gen_bit0", b0, 1'b1);
    chk("gen_bit1", b1, 1'b1);
    g = 16'hACE1;

    lock_check("clean");
    clean(1000);
    chk("clean_err_count", err_count, 0);
    chk("clean_still_locked", locked, 1'b1);

    beat(1'b1, 1'b0);
    chk("single_pulse", err_pulse, 1'b1);
    chk("single_count", err_count, 1);
    chk("single_locked", locked, 1'b1);
    clean(1);
    chk("single_pulse_clear", err_pulse, 1'b0);
    clean(50);
    chk("single_count_hold", err_count, 1);

    idle(1'b1);
    chk("clear_alone", err_count, 0);
    repeat (3) beat(1'b1, 1'b0);
    chk("unlock_3_locked", locked, 1'b1);
    beat(1'b1, 1'b0);
    chk("unlock_locked", locked, 1'b0);
    chk("unlock_pulse", err_pulse, 1'b1);
    chk("unlock_count", err_count, 4);
    lock_check("relock");

    idle(1'b1);
    repeat (3) beat(1'b1, 1'b0);
    clean(1);
    repeat (3) beat(1'b1, 1'b0);
    chk("variant_locked", locked, 1'b1);
    chk("variant_count", err_count, 6);
    clean(10);

    for (int k = 0; k < 3; k++) begin
      repeat (UNLOCK_ERRS) beat(1'b1, 1'b0);
      chk("sat_unlocked", locked, 1'b0);
      lock_check("sat_relock");
    end
    chk("sat_count", err_count, CNT_MAX);
    beat(1'b1, 1'b0);
    chk("sat_hold", err_count, CNT_MAX);
    beat(1'b1, 1'b1);
    chk("clr_inc_count", err_count, 1);
    chk("clr_inc_pulse", err_pulse, 1'b1);
    clean(2);

    do_reset();
    lock_check("post_reset");

    do_reset();
    for (int k = 0; k < LOCK_COUNT + 15; k++) begin
      beat(1'b0, 1'b0);
      idle(1'b0);
    end
    chk("gapped_pre_lock", locked, 1'b0);
    beat(1'b0, 1'b0);
    chk("gapped_lock", locked, 1'b1);
    idle(1'b0);
    chk("gapped_hold", locked, 1'b1);

    do_reset();
    repeat (200) raw_beat(1'b0, 1'b0);
    chk("stuck_locked", locked, 1'b0);
    chk("stuck_count", err_count, 0);

    idle(1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
